// File: rtl/exe_stage.sv
// Execute stage of the 16-bit RSA ASIP: single-cycle add/sub, a sequential
// multiply-low / modulo unit, and jump resolution against a registered zero flag.
module exe_stage #(
    parameter int ARQ = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic [ARQ-1:0] src1_in,
    input  logic [ARQ-1:0] src2_in,
    input  logic [ARQ-1:0] imm_in,
    input  logic [ARQ-1:0] srcdest_in,
    input  logic           mux_exe_in,
    input  logic [1:0]     alu_op_in,
    input  logic           wb_enable_in,
    input  logic           rd_mem_en_in,
    input  logic           wr_mem_en_in,
    input  logic           mux_mem_in,
    input  logic           jenable_in,
    input  logic           jop_lsb_in,
    input  logic [12:0]    jaddr_in,
    output logic [ARQ-1:0] res_out,
    output logic [ARQ-1:0] srcdest_out,
    output logic           wb_enable_out,
    output logic           rd_mem_en_out,
    output logic           wr_mem_en_out,
    output logic           mux_mem_out,
    output logic           valid_out,
    output logic           jtaken_out,
    output logic [12:0]    jaddr_out,
    output logic           zero_out,
    output logic           stall_out
);
    localparam int CW = $clog2(ARQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_mod_q, op_mod_d;
    logic [ARQ-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [ARQ-1:0] pend_sd_q, pend_sd_d;
    logic [3:0]     pend_ctl_q, pend_ctl_d;
    logic [ARQ-1:0] res_q, res_d, srcdest_q, srcdest_d;
    logic [3:0]     ctl_q, ctl_d;
    logic           valid_q, valid_d, jtaken_q, jtaken_d, zero_q, zero_d;
    logic [12:0]    jaddr_q, jaddr_d;

    logic [ARQ-1:0] opb, alu_res, mul_next, rem_next, iter_res;
    logic [ARQ:0]   rem_sh;
    logic           rem_ge;

    // One iteration of either unit; a_q supplies dividend bits MSB-first for mod.
    always_comb begin
        opb      = mux_exe_in ? imm_in : src2_in;
        alu_res  = alu_op_in[0] ? (src1_in - opb) : (src1_in + opb);
        mul_next = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_sh   = {acc_q, a_q[ARQ-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_next = rem_ge ? (rem_sh[ARQ-1:0] - b_q) : rem_sh[ARQ-1:0];
        iter_res = op_mod_q ? rem_next : mul_next;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_mod_d   = op_mod_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        pend_sd_d  = pend_sd_q;
        pend_ctl_d = pend_ctl_q;
        res_d      = res_q;
        srcdest_d  = srcdest_q;
        ctl_d      = ctl_q;
        zero_d     = zero_q;
        jaddr_d    = jaddr_q;
        valid_d    = 1'b0;
        jtaken_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (jenable_in) begin
                        jtaken_d = ~jop_lsb_in | zero_q;
                        jaddr_d  = jaddr_in;
                    end else if (!alu_op_in[1]) begin
                        res_d     = alu_res;
                        zero_d    = (alu_res == '0);
                        srcdest_d = srcdest_in;
                        ctl_d     = {wb_enable_in, rd_mem_en_in, wr_mem_en_in, mux_mem_in};
                        valid_d   = 1'b1;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = '0;
                        op_mod_d   = alu_op_in[0];
                        a_d        = src1_in;
                        b_d        = opb;
                        acc_d      = '0;
                        pend_sd_d  = srcdest_in;
                        pend_ctl_d = {wb_enable_in, rd_mem_en_in, wr_mem_en_in, mux_mem_in};
                    end
                end
            end
            BUSY: begin
                a_d   = a_q << 1;
                b_d   = op_mod_q ? b_q : (b_q >> 1);
                acc_d = iter_res;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ARQ-1)) begin
                    state_d   = IDLE;
                    res_d     = iter_res;
                    zero_d    = (iter_res == '0);
                    srcdest_d = pend_sd_q;
                    ctl_d     = pend_ctl_q;
                    valid_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_mod_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            pend_sd_q  <= '0;
            pend_ctl_q <= '0;
            res_q      <= '0;
            srcdest_q  <= '0;
            ctl_q      <= '0;
            zero_q     <= 1'b0;
            jaddr_q    <= '0;
            valid_q    <= 1'b0;
            jtaken_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_mod_q   <= op_mod_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            pend_sd_q  <= pend_sd_d;
            pend_ctl_q <= pend_ctl_d;
            res_q      <= res_d;
            srcdest_q  <= srcdest_d;
            ctl_q      <= ctl_d;
            zero_q     <= zero_d;
            jaddr_q    <= jaddr_d;
            valid_q    <= valid_d;
            jtaken_q   <= jtaken_d;
        end
    end

    assign res_out       = res_q;
    assign srcdest_out   = srcdest_q;
    assign wb_enable_out = ctl_q[3];
    assign rd_mem_en_out = ctl_q[2];
    assign wr_mem_en_out = ctl_q[1];
    assign mux_mem_out   = ctl_q[0];
    assign valid_out     = valid_q;
    assign jtaken_out    = jtaken_q;
    assign jaddr_out     = jaddr_q;
    assign zero_out      = zero_q;
    assign stall_out     = (state_q == BUSY);
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: inputs change 1ns after a rising edge, outputs
// are sampled there too, so each sample reflects the edge just taken.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] src1_in, src2_in, imm_in, srcdest_in;
    logic        mux_exe_in;
    logic [1:0]  alu_op_in;
    logic        wb_enable_in, rd_mem_en_in, wr_mem_en_in, mux_mem_in;
    logic        jenable_in, jop_lsb_in;
    logic [12:0] jaddr_in;
    logic [15:0] res_out, srcdest_out;
    logic        wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out;
    logic        valid_out, jtaken_out, zero_out, stall_out;
    logic [12:0] jaddr_out;

    int checks   = 0;
    int failures = 0;

    exe_stage #(.ARQ(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .src1_in(src1_in), .src2_in(src2_in), .imm_in(imm_in), .srcdest_in(srcdest_in),
        .mux_exe_in(mux_exe_in), .alu_op_in(alu_op_in),
        .wb_enable_in(wb_enable_in), .rd_mem_en_in(rd_mem_en_in),
        .wr_mem_en_in(wr_mem_en_in), .mux_mem_in(mux_mem_in),
        .jenable_in(jenable_in), .jop_lsb_in(jop_lsb_in), .jaddr_in(jaddr_in),
        .res_out(res_out), .srcdest_out(srcdest_out),
        .wb_enable_out(wb_enable_out), .rd_mem_en_out(rd_mem_en_out),
        .wr_mem_en_out(wr_mem_en_out), .mux_mem_out(mux_mem_out),
        .valid_out(valid_out), .jtaken_out(jtaken_out), .jaddr_out(jaddr_out),
        .zero_out(zero_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic mx, input logic je,
                         input logic jl, input logic [12:0] ja);
        valid_in   = v;
        alu_op_in  = op;
        src1_in    = a;
        src2_in    = mx ? 16'h0 : b;
        imm_in     = mx ? b : 16'hFFFF;
        mux_exe_in = mx;
        jenable_in = je;
        jop_lsb_in = jl;
        jaddr_in   = ja;
    endtask

    task automatic idle_in();
        issue(1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 13'h0);
    endtask

    // Issues a mul/mod, then watches 20 more edges for stall cycles and valid pulses.
    task automatic run_multi(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             output int stalls, output int valids,
                             output logic [15:0] res, output logic z);
        stalls = 0; valids = 0; res = 16'hxxxx; z = 1'bx;
        issue(1'b1, op, a, b, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        idle_in();
        if (stall_out) stalls++;
        repeat (20) begin
            step();
            if (stall_out) stalls++;
            if (valid_out) begin valids++; res = res_out; z = zero_out; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        srcdest_in = 16'h0; wb_enable_in = 0; rd_mem_en_in = 0; wr_mem_en_in = 0; mux_mem_in = 0;
        step(); step();
        checks++;
        if ({res_out, srcdest_out, valid_out, jtaken_out, jaddr_out, zero_out, stall_out,
             wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out} !== '0) begin
            failures++; $display("FAIL reset_state res=%h sd=%h v=%b st=%b", res_out, srcdest_out, valid_out, stall_out);
        end
        rst = 1'b0;
        step();
        // mul in flight, reset once counter has reached 7
        issue(1'b1, 2'b10, 16'h0123, 16'h0045, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        idle_in();
        repeat (7) step();
        checks++;
        if (stall_out !== 1'b1) begin failures++; $display("FAIL midreset_busy stall=%b exp 1", stall_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({res_out, valid_out, stall_out, zero_out, jtaken_out} !== '0) begin
            failures++; $display("FAIL midreset_clear res=%h v=%b st=%b exp all 0", res_out, valid_out, stall_out);
        end
        begin
            int pulses = 0;
            repeat (20) begin step(); if (valid_out || stall_out) pulses++; end
            checks++;
            if (pulses != 0) begin failures++; $display("FAIL midreset_nopulse got=%0d exp 0", pulses); end
        end
    endtask

    task automatic test_addsub();
        srcdest_in = 16'h1111; wb_enable_in = 1; rd_mem_en_in = 0; wr_mem_en_in = 1; mux_mem_in = 0;
        issue(1'b1, 2'b00, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 13'h0);
        step();
        idle_in();
        checks++;
        if (res_out !== 16'h8000 || valid_out !== 1'b1 || zero_out !== 1'b0) begin
            failures++; $display("FAIL add_imm res=%h v=%b z=%b exp 8000 1 0", res_out, valid_out, zero_out);
        end
        checks++;
        if ({srcdest_out, wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out} !== {16'h1111, 4'b1010}) begin
            failures++; $display("FAIL add_pass sd=%h ctl=%b%b%b%b exp 1111 1010", srcdest_out,
                                 wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out);
        end
        step();
        checks++;
        if (valid_out !== 1'b0) begin failures++; $display("FAIL add_pulse v=%b exp 0", valid_out); end
        issue(1'b1, 2'b01, 16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        idle_in();
        checks++;
        if (res_out !== 16'h0 || valid_out !== 1'b1 || zero_out !== 1'b1) begin
            failures++; $display("FAIL sub_zero res=%h v=%b z=%b exp 0000 1 1", res_out, valid_out, zero_out);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b00, 16'd10, 16'd20, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        issue(1'b1, 2'b01, 16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 13'h0);
        checks++;
        if (res_out !== 16'd30 || valid_out !== 1'b1) begin failures++; $display("FAIL b2b_0 res=%h v=%b exp 001e 1", res_out, valid_out); end
        step();
        issue(1'b1, 2'b00, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 13'h0);
        checks++;
        if (res_out !== 16'hFFFE || valid_out !== 1'b1) begin failures++; $display("FAIL b2b_1 res=%h v=%b exp fffe 1", res_out, valid_out); end
        step();
        idle_in();
        checks++;
        if (res_out !== 16'h0000 || valid_out !== 1'b1 || zero_out !== 1'b1) begin
            failures++; $display("FAIL b2b_2 res=%h v=%b z=%b exp 0000 1 1", res_out, valid_out, zero_out);
        end
        step();
    endtask

    task automatic test_mul();
        int st, vc; logic [15:0] r; logic z;
        run_multi(2'b10, 16'h0123, 16'h0045, st, vc, r, z);
        checks++;
        if (st != 16 || vc != 1 || r !== 16'h4E6F) begin
            failures++; $display("FAIL mul_small stalls=%0d valids=%0d res=%h exp 16 1 4e6f", st, vc, r);
        end
        run_multi(2'b10, 16'hFFFF, 16'hFFFF, st, vc, r, z);
        checks++;
        if (vc != 1 || r !== 16'h0001 || z !== 1'b0) begin
            failures++; $display("FAIL mul_ovf valids=%0d res=%h z=%b exp 1 0001 0", vc, r, z);
        end
    endtask

    task automatic test_mod();
        int st, vc; logic [15:0] r; logic z;
        run_multi(2'b11, 16'd1000, 16'd7, st, vc, r, z);
        checks++;
        if (st != 16 || vc != 1 || r !== 16'd6) begin
            failures++; $display("FAIL mod_1000_7 stalls=%0d valids=%0d res=%h exp 16 1 0006", st, vc, r);
        end
        run_multi(2'b11, 16'h1234, 16'h0000, st, vc, r, z);
        checks++;
        if (vc != 1 || r !== 16'h1234 || z !== 1'b0) begin
            failures++; $display("FAIL mod_by_zero valids=%0d res=%h z=%b exp 1 1234 0", vc, r, z);
        end
    endtask

    task automatic test_jump();
        issue(1'b1, 2'b01, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        issue(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 13'h0ABC);
        step();
        idle_in();
        checks++;
        if (jtaken_out !== 1'b1 || jaddr_out !== 13'h0ABC || valid_out !== 1'b0 || zero_out !== 1'b1) begin
            failures++; $display("FAIL jz_taken jt=%b ja=%h v=%b z=%b exp 1 0abc 0 1", jtaken_out, jaddr_out, valid_out, zero_out);
        end
        step();
        checks++;
        if (jtaken_out !== 1'b0) begin failures++; $display("FAIL jz_pulse jt=%b exp 0", jtaken_out); end
        issue(1'b1, 2'b00, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        issue(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 13'h0ABC);
        step();
        checks++;
        if (jtaken_out !== 1'b0 || zero_out !== 1'b0) begin
            failures++; $display("FAIL jz_not_taken jt=%b z=%b exp 0 0", jtaken_out, zero_out);
        end
        issue(1'b1, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 13'h1555);
        step();
        idle_in();
        checks++;
        if (jtaken_out !== 1'b1 || jaddr_out !== 13'h1555) begin
            failures++; $display("FAIL j_uncond jt=%b ja=%h exp 1 1555", jtaken_out, jaddr_out);
        end
        step();
    endtask

    task automatic test_busy_ignore();
        int early = 0;
        srcdest_in = 16'hBEEF; wb_enable_in = 1; rd_mem_en_in = 1; wr_mem_en_in = 0; mux_mem_in = 1;
        issue(1'b1, 2'b10, 16'h0123, 16'h0045, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        for (int i = 1; i <= 16; i++) begin
            issue(i[0], 2'b00, 16'(i * 257), 16'h0101, 1'b0, 1'b0, 1'b0, 13'h0);
            srcdest_in = 16'(i);
            wb_enable_in = 0; rd_mem_en_in = 0; mux_mem_in = 0;
            step();
            if (i < 16 && valid_out) early++;
        end
        checks++;
        if (early != 0) begin failures++; $display("FAIL busy_early_valid got=%0d exp 0", early); end
        checks++;
        if (valid_out !== 1'b1 || res_out !== 16'h4E6F || stall_out !== 1'b0) begin
            failures++; $display("FAIL busy_result v=%b res=%h st=%b exp 1 4e6f 0", valid_out, res_out, stall_out);
        end
        checks++;
        if ({srcdest_out, wb_enable_out, rd_mem_en_out, wr_mem_en_out, mux_mem_out} !== {16'hBEEF, 4'b1101}) begin
            failures++; $display("FAIL busy_pass sd=%h exp beef ctl 1101", srcdest_out);
        end
        issue(1'b1, 2'b00, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 13'h0);
        step();
        idle_in();
        checks++;
        if (valid_out !== 1'b1 || res_out !== 16'd7) begin
            failures++; $display("FAIL accept_n17 v=%b res=%h exp 1 0007", valid_out, res_out);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_back_to_back();
        test_mul();
        test_mod();
        test_jump();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
